pwm_sequencer: RTL and testbench



---
 rtl/pwm_sequencer.sv | 227 ++++++++++++++++++++++
 tb/tb_pwm_sequencer.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_sequencer.sv
// PWM gate-drive sequencer: fixed-frequency PWM with soft-start/soft-stop duty ramps
// and period-boundary application of handshaked period/duty/step settings.
module pwm_sequencer #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic [CNT_WIDTH-1:0] cfg_period,
    input  logic [CNT_WIDTH-1:0] cfg_duty,
    input  logic [CNT_WIDTH-1:0] cfg_step,
    output logic                 ctrl,
    output logic                 period_start,
    output logic [CNT_WIDTH-1:0] duty_cur,
    output logic [1:0]           state,
    output logic                 at_target
);

    localparam int W = CNT_WIDTH;
    localparam logic [W-1:0] MIN_PERIOD = W'(2);
    localparam logic [W-1:0] ZERO       = '0;
    localparam logic [W-1:0] ONE        = W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RAMP = 2'd1,
        RUN  = 2'd2,
        STOP = 2'd3
    } state_t;

    state_t         state_q;
    state_t         state_d;
    logic [W-1:0]   cnt_q;
    logic [W-1:0]   cnt_d;
    logic [W-1:0]   duty_cur_q;
    logic [W-1:0]   duty_cur_d;
    logic [W-1:0]   period_a_q;
    logic [W-1:0]   period_a_d;
    logic [W-1:0]   duty_a_q;
    logic [W-1:0]   duty_a_d;
    logic [W-1:0]   step_a_q;
    logic [W-1:0]   step_a_d;
    logic [W-1:0]   sh_period_q;
    logic [W-1:0]   sh_period_d;
    logic [W-1:0]   sh_duty_q;
    logic [W-1:0]   sh_duty_d;
    logic [W-1:0]   sh_step_q;
    logic [W-1:0]   sh_step_d;
    logic           pending_q;
    logic           pending_d;
    logic           ctrl_q;
    logic           ctrl_d;

    logic           boundary;
    logic           xfer;
    logic           copy;
    logic [W-1:0]   cur_period;
    logic [W-1:0]   cur_target;
    logic [W-1:0]   nx_period;
    logic [W-1:0]   nx_duty;
    logic [W-1:0]   nx_step;
    logic [W-1:0]   nx_target;
    logic [W-1:0]   duty_step;

    function automatic logic [W-1:0] eff_period(input logic [W-1:0] p);
        return (p < MIN_PERIOD) ? MIN_PERIOD : p;
    endfunction

    function automatic logic [W-1:0] clamp_target(input logic [W-1:0] d,
                                                  input logic [W-1:0] p_eff);
        return (d > p_eff) ? p_eff : d;
    endfunction

    // Saturating move of cur toward tgt by stp; the sum is one bit wider so it never wraps.
    function automatic logic [W-1:0] step_toward(input logic [W-1:0] cur,
                                                 input logic [W-1:0] tgt,
                                                 input logic [W-1:0] stp);
        logic [W:0] sum;
        sum = {1'b0, cur} + {1'b0, stp};
        if (stp == ZERO) begin
            return tgt;
        end else if (cur < tgt) begin
            return (sum >= {1'b0, tgt}) ? tgt : sum[W-1:0];
        end else if (cur > tgt) begin
            return (stp >= (cur - tgt)) ? tgt : (cur - stp);
        end else begin
            return cur;
        end
    endfunction

    // ------------------------------------------------------------------
    // Datapath: clamping, boundary detection, shadow copy and duty update
    // ------------------------------------------------------------------
    always_comb begin
        cur_period = eff_period(period_a_q);
        cur_target = (state_q == STOP) ? ZERO : clamp_target(duty_a_q, cur_period);
        boundary   = (state_q != IDLE) && (cnt_q >= (cur_period - ONE));
        xfer       = cfg_valid && !pending_q;
        copy       = pending_q && ((state_q == IDLE) || boundary);

        nx_period  = copy ? sh_period_q : period_a_q;
        nx_duty    = copy ? sh_duty_q   : duty_a_q;
        nx_step    = copy ? sh_step_q   : step_a_q;
        nx_target  = (state_q == STOP) ? ZERO
                                       : clamp_target(nx_duty, eff_period(nx_period));
        duty_step  = step_toward(duty_cur_q, nx_target, nx_step);
    end

    always_comb begin
        period_a_d  = nx_period;
        duty_a_d    = nx_duty;
        step_a_d    = nx_step;
        sh_period_d = sh_period_q;
        sh_duty_d   = sh_duty_q;
        sh_step_d   = sh_step_q;
        pending_d   = pending_q;

        if (copy) begin
            pending_d = 1'b0;
        end
        if (xfer) begin
            sh_period_d = cfg_period;
            sh_duty_d   = cfg_duty;
            sh_step_d   = cfg_step;
            pending_d   = 1'b1;
        end
    end

    always_comb begin
        cnt_d      = cnt_q + ONE;
        duty_cur_d = duty_cur_q;
        if (state_q == IDLE) begin
            cnt_d      = ZERO;
            duty_cur_d = ZERO;
        end else if (boundary) begin
            cnt_d      = ZERO;
            duty_cur_d = duty_step;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q       <= ZERO;
            duty_cur_q  <= ZERO;
            period_a_q  <= MIN_PERIOD;
            duty_a_q    <= ZERO;
            step_a_q    <= ZERO;
            sh_period_q <= ZERO;
            sh_duty_q   <= ZERO;
            sh_step_q   <= ZERO;
            pending_q   <= 1'b0;
            ctrl_q      <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            duty_cur_q  <= duty_cur_d;
            period_a_q  <= period_a_d;
            duty_a_q    <= duty_a_d;
            step_a_q    <= step_a_d;
            sh_period_q <= sh_period_d;
            sh_duty_q   <= sh_duty_d;
            sh_step_q   <= sh_step_d;
            pending_q   <= pending_d;
            ctrl_q      <= ctrl_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register, next-state logic, output logic
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (en) begin
                    state_d = RAMP;
                end
            end
            RAMP: begin
                if (!en) begin
                    state_d = STOP;
                end else if (boundary && (duty_step == nx_target)) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                // A new target reached in one update (step 0) keeps the FSM in RUN.
                if (!en) begin
                    state_d = STOP;
                end else if (boundary && (duty_step != nx_target)) begin
                    state_d = RAMP;
                end
            end
            STOP: begin
                if (en) begin
                    state_d = RAMP;
                end else if (boundary && (duty_step == ZERO)) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        ctrl_d       = (state_q != IDLE) && (cnt_q < duty_cur_q);
        period_start = (state_q != IDLE) && (cnt_q == ZERO);
        cfg_ready    = !pending_q;
        at_target    = (duty_cur_q == cur_target);
    end

    assign ctrl     = ctrl_q;
    assign duty_cur = duty_cur_q;
    assign state    = state_q;

endmodule

// File: tb/tb_pwm_sequencer.sv
// Bench for pwm_sequencer: the stimulus pushes one expected record per PWM period
// {state, duty, length, high cycles}; a monitor measures each period and compares.
module tb_pwm_sequencer;

    localparam int W  = 16;
    localparam int RW = 50;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RAMP = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_STOP = 2'd3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic          cfg_valid = 1'b0;
    logic          cfg_ready;
    logic [W-1:0]  cfg_period = '0;
    logic [W-1:0]  cfg_duty = '0;
    logic [W-1:0]  cfg_step = '0;
    logic          ctrl;
    logic          period_start;
    logic [W-1:0]  duty_cur;
    logic [1:0]    state;
    logic          at_target;

    int            total = 0;
    int            bad = 0;
    logic [RW-1:0] exp_q[$];
    bit            mon_on = 1'b1;

    pwm_sequencer #(.CNT_WIDTH(W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_period   (cfg_period),
        .cfg_duty     (cfg_duty),
        .cfg_step     (cfg_step),
        .ctrl         (ctrl),
        .period_start (period_start),
        .duty_cur     (duty_cur),
        .state        (state),
        .at_target    (at_target)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

    function automatic logic [RW-1:0] rec(input logic [1:0] st, input int du,
                                          input int ln, input int hi);
        return {st, du[15:0], ln[15:0], hi[15:0]};
    endfunction

    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d required %0d", name, got, exp);
        end
    endtask

    task automatic send_cfg(input int p, input int d, input int s);
        int n;
        tick();
        cfg_period = 16'(p);
        cfg_duty   = 16'(d);
        cfg_step   = 16'(s);
        cfg_valid  = 1'b1;
        n = 0;
        while (!cfg_ready && n < 200) begin
            tick();
            n++;
        end
        if (!cfg_ready) begin
            total++;
            bad++;
            $display("FAIL cfg_accept: cfg_ready never rose, required 1");
        end
        tick();
        check("ready_low_after_xfer", 32'(cfg_ready), 32'd0);
        cfg_valid = 1'b0;
    endtask

    task automatic wait_pstart(input string name);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!period_start && n < 200);
        if (!period_start) begin
            total++;
            bad++;
            $display("FAIL %s: period_start not seen, got 0 required 1", name);
        end
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            tick();
            n++;
        end
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_%s: got %0d periods outstanding required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    // monitor / scoreboard: one record per completed PWM period
    initial begin
        bit            open;
        int            hi;
        int            ln;
        int            pidx;
        logic [1:0]    st_s;
        logic [15:0]   du_s;
        logic [RW-1:0] got;
        logic [RW-1:0] exp;
        open = 1'b0;
        hi = 0;
        ln = 0;
        pidx = 0;
        st_s = '0;
        du_s = '0;
        forever begin
            @(negedge clk);
            if (!rst_n || !mon_on) begin
                open = 1'b0;
            end else begin
                if (open) begin
                    hi += int'(ctrl);
                    ln++;
                end
                if (open && (period_start || state == S_IDLE)) begin
                    got = {st_s, du_s, ln[15:0], hi[15:0]};
                    total++;
                    if (exp_q.size() == 0) begin
                        bad++;
                        $display("FAIL period[%0d]: unexpected period st=%0d duty=%0d len=%0d high=%0d, required none",
                                 pidx, st_s, du_s, ln, hi);
                    end else begin
                        exp = exp_q.pop_front();
                        if (got !== exp) begin
                            bad++;
                            $display("FAIL period[%0d]: got st=%0d duty=%0d len=%0d high=%0d required st=%0d duty=%0d len=%0d high=%0d",
                                     pidx, got[49:48], got[47:32], got[31:16], got[15:0],
                                     exp[49:48], exp[47:32], exp[31:16], exp[15:0]);
                        end
                    end
                    pidx++;
                    open = 1'b0;
                end
                if (period_start) begin
                    open = 1'b1;
                    hi   = 0;
                    ln   = 0;
                    st_s = state;
                    du_s = duty_cur;
                end
            end
        end
    end

    // driver: directed phases
    initial begin
        int acc;
        int last_p;
        int last_d;

        // reset state
        repeat (3) tick();
        check("rst_ctrl", 32'(ctrl), 32'd0);
        check("rst_state", 32'(state), 32'(S_IDLE));
        check("rst_duty_cur", 32'(duty_cur), 32'd0);
        check("rst_period_start", 32'(period_start), 32'd0);
        check("rst_cfg_ready", 32'(cfg_ready), 32'd1);
        check("rst_at_target", 32'(at_target), 32'd1);
        rst_n = 1'b1;
        tick();

        // soft-start 0..5 with step 1
        send_cfg(10, 5, 1);
        tick();
        check("idle_copy_ready", 32'(cfg_ready), 32'd1);
        check("idle_not_at_target", 32'(at_target), 32'd0);
        for (int d = 0; d < 5; d++) exp_q.push_back(rec(S_RAMP, d, 10, d));
        exp_q.push_back(rec(S_RUN, 5, 10, 5));
        exp_q.push_back(rec(S_RUN, 5, 10, 5));
        en = 1'b1;
        drain("soft_start");
        check("run_state", 32'(state), 32'(S_RUN));
        check("run_at_target", 32'(at_target), 32'd1);

        // step-0 jump, duty clamped to period
        exp_q.push_back(rec(S_RUN, 5, 10, 5));
        exp_q.push_back(rec(S_RUN, 10, 10, 10));
        exp_q.push_back(rec(S_RUN, 10, 10, 10));
        send_cfg(10, 15, 0);
        drain("jump");
        check("clamp_duty_cur", 32'(duty_cur), 32'd10);
        check("clamp_at_target", 32'(at_target), 32'd1);

        // period 1 runs as period 2
        exp_q.push_back(rec(S_RUN, 10, 10, 10));
        for (int k = 0; k < 3; k++) exp_q.push_back(rec(S_RUN, 1, 2, 1));
        send_cfg(1, 1, 0);
        drain("min_period");

        // back to period 10 duty 5
        exp_q.push_back(rec(S_RUN, 1, 2, 1));
        exp_q.push_back(rec(S_RUN, 1, 2, 1));
        exp_q.push_back(rec(S_RUN, 5, 10, 5));
        exp_q.push_back(rec(S_RUN, 5, 10, 5));
        send_cfg(10, 5, 0);
        drain("restore");

        // run-time change mid-period
        exp_q.push_back(rec(S_RUN, 5, 10, 5));
        exp_q.push_back(rec(S_RAMP, 3, 20, 3));
        exp_q.push_back(rec(S_RUN, 2, 20, 2));
        exp_q.push_back(rec(S_RUN, 2, 20, 2));
        repeat (3) tick();
        send_cfg(20, 2, 2);
        repeat (2) tick();
        check("ready_held_low", 32'(cfg_ready), 32'd0);
        drain("runtime_change");
        check("change_state", 32'(state), 32'(S_RUN));
        check("change_duty", 32'(duty_cur), 32'd2);
        check("change_ready", 32'(cfg_ready), 32'd1);

        // ramp up to 5 with step 2
        exp_q.push_back(rec(S_RUN, 2, 20, 2));
        exp_q.push_back(rec(S_RAMP, 4, 10, 4));
        exp_q.push_back(rec(S_RUN, 5, 10, 5));
        send_cfg(10, 5, 2);
        drain("ramp_step2");

        // soft-stop then restart at duty 1
        exp_q.push_back(rec(S_RUN, 5, 10, 5));
        exp_q.push_back(rec(S_STOP, 3, 10, 3));
        exp_q.push_back(rec(S_STOP, 1, 10, 1));
        exp_q.push_back(rec(S_RAMP, 3, 10, 3));
        exp_q.push_back(rec(S_RUN, 5, 10, 5));
        tick();
        en = 1'b0;
        wait_pstart("stop_p1");
        wait_pstart("stop_p2");
        repeat (2) tick();
        check("stop_duty1", 32'(duty_cur), 32'd1);
        check("stop_state", 32'(state), 32'(S_STOP));
        en = 1'b1;
        tick();
        check("restart_state", 32'(state), 32'(S_RAMP));
        drain("restart");

        // full stop to IDLE
        exp_q.push_back(rec(S_RUN, 5, 10, 5));
        exp_q.push_back(rec(S_STOP, 3, 10, 3));
        exp_q.push_back(rec(S_STOP, 1, 10, 1));
        tick();
        en = 1'b0;
        drain("full_stop");
        check("idle_state", 32'(state), 32'(S_IDLE));
        check("idle_duty", 32'(duty_cur), 32'd0);
        acc = 0;
        repeat (10) begin
            tick();
            if (period_start || ctrl) acc++;
        end
        check("idle_cnt_held", 32'(acc), 32'd0);

        // mid-run reset with a pending config
        send_cfg(10, 5, 0);
        exp_q.push_back(rec(S_RAMP, 0, 10, 0));
        exp_q.push_back(rec(S_RUN, 5, 10, 5));
        en = 1'b1;
        drain("pre_reset");
        mon_on = 1'b0;
        send_cfg(30, 7, 1);
        check("pre_reset_ctrl", 32'(ctrl), 32'd1);
        rst_n = 1'b0;
        tick();
        check("reset_ctrl", 32'(ctrl), 32'd0);
        check("reset_state", 32'(state), 32'(S_IDLE));
        check("reset_ready", 32'(cfg_ready), 32'd1);
        exp_q.push_back(rec(S_RAMP, 0, 2, 0));
        exp_q.push_back(rec(S_RUN, 0, 2, 0));
        exp_q.push_back(rec(S_RUN, 0, 2, 0));
        rst_n  = 1'b1;
        mon_on = 1'b1;
        drain("post_reset");

        // backpressure: cfg_valid held with data changing every cycle
        exp_q.push_back(rec(S_RUN, 0, 2, 0));
        exp_q.push_back(rec(S_RUN, 0, 2, 0));
        acc = 0;
        last_p = 0;
        last_d = 0;
        for (int i = 0; i < 200 && acc < 3; i++) begin
            tick();
            cfg_period = 16'(5 + i % 4);
            cfg_duty   = 16'(1 + i % 3);
            cfg_step   = '0;
            cfg_valid  = 1'b1;
            if (cfg_ready) begin
                if (acc > 0) check("accept_at_period_start", 32'(period_start), 32'd1);
                last_p = 5 + i % 4;
                last_d = 1 + i % 3;
                exp_q.push_back(rec(S_RUN, last_d, last_p, last_d));
                acc++;
            end
        end
        check("accept_count", 32'(acc), 32'd3);
        tick();
        cfg_valid = 1'b0;
        exp_q.push_back(rec(S_RUN, last_d, last_p, last_d));
        drain("backpressure");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
